pht_multiport_sat: RTL
======================

// Module: pht_multiport_sat
// PURPOSE
//  Pattern history table of saturating counters with N prediction read ports and M update ports.
//  Successor of the 2-port/2-bit PHT: counter width, read and update port counts are parametrised.
//  Adds a reset/clear initialisation sweep, a ready flag and defined same-index collision rules.
//  Sits between the branch predictor index hash (fetch side) and the reorder buffer retire path.
// PARAMETERS
//  PHT_ADDRESS   9   index width; table depth = 2**PHT_ADDRESS entries
//  COUNTER_SIZE  2   counter width in bits, >=2; prediction = counter MSB
//  NUM_READ      2   number of prediction read ports, >=1
//  NUM_UPDATE    1   number of retire update ports, 1..4
//  INIT_VALUE    (1<<(COUNTER_SIZE-1))-1   value written by sweep (weakly not-taken)
// PORTS
//  CLK           in   1                     clock, all state on posedge
//  reset         in   1                     synchronous, active-high
//  clear         in   1                     restart init sweep (context flush)
//  pht_index     in   NUM_READ*PHT_ADDRESS  read indices, port i at [i*PHT_ADDRESS +: PHT_ADDRESS]
//  pred_taken    out  NUM_READ              registered prediction per read port
//  pred_ctr      out  NUM_READ*COUNTER_SIZE registered raw counter per read port
//  update_pht    in   NUM_UPDATE            update strobe per update port
//  rb_pht_index  in   NUM_UPDATE*PHT_ADDRESS update indices
//  actual_taken  in   NUM_UPDATE            resolved outcome per update port
//  ready         out  1                     1 = table initialised, predictions valid
// BEHAVIOUR
//  - Reset (sync, active-high): state<=INIT, sweep ptr<=0, ready<=0, pred_taken<=0, pred_ctr<=0.
//  - FSM INIT: each cycle write INIT_VALUE to PHT[ptr], ptr++; on ptr==DEPTH-1 write then ->READY,
//    ready<=1 next cycle. Sweep takes exactly 2**PHT_ADDRESS cycles after reset deasserts.
//  - FSM READY: clear=1 -> INIT, ptr<=0, ready<=0. clear during INIT restarts sweep at ptr 0.
//  - In INIT (or clear cycle): update_pht ignored, pred_taken/pred_ctr forced to 0.
//  - Reads: 1-cycle latency; pred_ctr[i] <= PHT[pht_index[i]], pred_taken[i] <= its MSB. Every cycle.
//  - Update: taken -> ctr+1 saturating at 2**COUNTER_SIZE-1; not taken -> ctr-1 saturating at 0.
//    Write lands at posedge; visible to reads issued the following cycle.
//  - Same-index updates in one cycle: applied sequentially in port order 0..M-1, each saturating,
//    single resulting write (e.g. 3 taken + not-taken on 2-bit -> 2; 0 not-taken + taken -> 1).
//  - Distinct-index updates in one cycle all commit independently.
//  - Read of index written same cycle: old value returned (unless PHT_BYPASS_EN).
//  - Storage has no reset of its own; only the sweep defines contents. ram_style block when M==1.
// CONFIGURATION
//  PHT_BYPASS_EN defined: a read whose index matches any active update in the same cycle returns
//    the post-update counter (final value after port-order combination).
//  PHT_BYPASS_EN undefined: same-cycle read returns the pre-update counter; no forwarding logic.
// TESTING
//  1. reset 1 cycle, PHT_ADDRESS=4 -> ready=0 for 16 cycles, ready=1 on cycle 17; all reads ctr=1, taken=0.
//  2. 3x update taken idx 5, then read idx 5 -> ctr 1->2->3->3 (saturate), pred_taken=1.
//  3. NUM_UPDATE=2, both idx 7 (ctr=3): port0 taken, port1 not-taken -> ctr=2; ctr=0 with nt,t -> 1.
//  4. Read idx 9 same cycle as taken update idx 9 (ctr=1) -> pred_ctr=1 w/o bypass, 2 with PHT_BYPASS_EN.
//  5. clear mid-READY after training idx 3 to 3 -> ready=0, updates dropped, after sweep idx 3 ctr=1.
//  6. reset asserted at sweep ptr=8 -> sweep restarts at 0, ready only after full 16 further cycles.

Source files
------------

// File: rtl/pht_multiport_sat.sv
// Pattern history table of saturating counters: NUM_READ registered prediction ports, NUM_UPDATE retire ports.
// Optional same-cycle update-to-read forwarding is enabled by defining PHT_BYPASS_EN.

module pht_rd_lane #(
   parameter int COUNTER_SIZE = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [COUNTER_SIZE-1:0] ctr,
   output logic                    pred_taken,
   output logic [COUNTER_SIZE-1:0] pred_ctr
);
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         pred_taken <= 1'b0;
         pred_ctr   <= '0;
      end else begin
         pred_taken <= ctr[COUNTER_SIZE-1];
         pred_ctr   <= ctr;
      end
   end
endmodule

module pht_multiport_sat #(
   parameter int PHT_ADDRESS  = 9,
   parameter int COUNTER_SIZE = 2,
   parameter int NUM_READ     = 2,
   parameter int NUM_UPDATE   = 1,
   parameter logic [COUNTER_SIZE-1:0] INIT_VALUE = COUNTER_SIZE'((1 << (COUNTER_SIZE-1)) - 1)
) (
   input  logic                             CLK,
   input  logic                             reset,
   input  logic                             clear,
   input  logic [NUM_READ*PHT_ADDRESS-1:0]  pht_index,
   output logic [NUM_READ-1:0]              pred_taken,
   output logic [NUM_READ*COUNTER_SIZE-1:0] pred_ctr,
   input  logic [NUM_UPDATE-1:0]            update_pht,
   input  logic [NUM_UPDATE*PHT_ADDRESS-1:0] rb_pht_index,
   input  logic [NUM_UPDATE-1:0]            actual_taken,
   output logic                             ready
);
   localparam int DEPTH = 1 << PHT_ADDRESS;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                   state_q, state_d;
   logic [PHT_ADDRESS-1:0]   ptr_q, ptr_d;
   logic                     sweep_we;
   logic                     active;

   logic [NUM_READ-1:0][PHT_ADDRESS-1:0]    rd_idx;
   logic [NUM_READ-1:0][COUNTER_SIZE-1:0]   rd_raw, rd_val;
   logic [NUM_UPDATE-1:0][PHT_ADDRESS-1:0]  up_idx;
   logic [NUM_UPDATE-1:0][COUNTER_SIZE-1:0] up_old, wr_val;
   logic [NUM_UPDATE-1:0]                   up_act, wr_en;

   assign rd_idx = pht_index;
   assign up_idx = rb_pht_index;
   assign active = (state_q == ST_READY) && !clear && !reset;

   function automatic logic [COUNTER_SIZE-1:0] sat_step(input logic [COUNTER_SIZE-1:0] v,
                                                        input logic t);
      if (t) return (v == '1) ? v : v + COUNTER_SIZE'(1);
      else   return (v == '0) ? v : v - COUNTER_SIZE'(1);
   endfunction

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sweep_we = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (clear) begin
               ptr_d = '0;
            end else begin
               sweep_we = !reset;
               ptr_d    = ptr_q + PHT_ADDRESS'(1);
               if (ptr_q == '1) state_d = ST_READY;
            end
         end
         default: begin
            if (clear) begin
               state_d = ST_INIT;
               ptr_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ready   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ready   <= (state_d == ST_READY);
      end
   end

   // Same-index updates fold in port order; only the last such port writes the folded value.
   always_comb begin
      for (int j = 0; j < NUM_UPDATE; j++) begin
         up_act[j] = active && update_pht[j];
         wr_en[j]  = up_act[j];
         wr_val[j] = up_old[j];
         for (int k = 0; k < NUM_UPDATE; k++) begin
            if (k <= j && up_act[k] && up_idx[k] == up_idx[j])
               wr_val[j] = sat_step(wr_val[j], actual_taken[k]);
            if (k > j && up_act[k] && up_idx[k] == up_idx[j])
               wr_en[j] = 1'b0;
         end
      end
   end

   generate
      if (NUM_UPDATE == 1) begin : g_bram
         (* ram_style = "block" *) logic [COUNTER_SIZE-1:0] mem [DEPTH];
         always_ff @(posedge CLK) begin
            if (sweep_we) mem[ptr_q] <= INIT_VALUE;
            else if (wr_en[0]) mem[up_idx[0]] <= wr_val[0];
         end
         always_comb begin
            for (int i = 0; i < NUM_READ; i++) rd_raw[i] = mem[rd_idx[i]];
            up_old[0] = mem[up_idx[0]];
         end
      end else begin : g_multi
         logic [COUNTER_SIZE-1:0] mem [DEPTH];
         always_ff @(posedge CLK) begin
            if (sweep_we) mem[ptr_q] <= INIT_VALUE;
            else
               for (int j = 0; j < NUM_UPDATE; j++)
                  if (wr_en[j]) mem[up_idx[j]] <= wr_val[j];
         end
         always_comb begin
            for (int i = 0; i < NUM_READ; i++)   rd_raw[i] = mem[rd_idx[i]];
            for (int j = 0; j < NUM_UPDATE; j++) up_old[j] = mem[up_idx[j]];
         end
      end
   endgenerate

   always_comb begin
      rd_val = rd_raw;
`ifdef PHT_BYPASS_EN
      for (int i = 0; i < NUM_READ; i++)
         for (int j = 0; j < NUM_UPDATE; j++)
            if (wr_en[j] && up_idx[j] == rd_idx[i]) rd_val[i] = wr_val[j];
`endif
   end

   generate
      for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
         pht_rd_lane #(.COUNTER_SIZE(COUNTER_SIZE)) u_lane (
            .clk        (CLK),
            .reset      (reset),
            .en         (active),
            .ctr        (rd_val[i]),
            .pred_taken (pred_taken[i]),
            .pred_ctr   (pred_ctr[i*COUNTER_SIZE +: COUNTER_SIZE])
         );
      end
   endgenerate
endmodule
